rx_tlu_arbiter: RTL and testbench
=================================

// Module: rx_tlu_arbiter
// PURPOSE
//  Merges FE-I4 receiver words (24 bit) and TLU trigger words (31 bit) into one
//  32-bit first-word-fall-through stream for the SRAM out_fifo. Sits between
//  fei4_rx/tlu_controller (upstream) and out_fifo (downstream), all on BUS_CLK.
//  TLU words carry bit31=1, FE words bit31=0. TLU words have strict priority.
// PARAMETERS
//  TLU_DEPTH  4      TLU word buffer depth; power of two, 2..16
//  FE_HEADER  8'h01  FE word bits[31:24], used only with RX_TLU_ARB_HEADER_EN
// PORTS
//  BUS_CLK            in   1   single clock for the whole block
//  BUS_RST            in   1   asynchronous, active-high reset
//  FE_FIFO_EMPTY      in   1   fei4_rx FWFT FIFO empty
//  FE_FIFO_DATA       in   24  fei4_rx FWFT head word, valid while !FE_FIFO_EMPTY
//  FE_FIFO_READ       out  1   1-cycle pop of fei4_rx FIFO
//  TLU_DATA_SAVE_FLAG in   1   1-cycle pulse: TLU_DATA valid this cycle
//  TLU_DATA           in   31  trigger number/timestamp word
//  TLU_DATA_SAVED_FLAG out 1   1-cycle ack, TLU word accepted into buffer
//  FIFO_READ_NEXT     in   1   out_fifo pops current output word
//  FIFO_EMPTY         out  1   no valid output word
//  FIFO_DATA          out  32  output word, valid while !FIFO_EMPTY
//  TLU_OVERFLOW       out  1   sticky: TLU word dropped on full buffer
//  READ_ERROR         out  1   sticky: FIFO_READ_NEXT while FIFO_EMPTY
// BEHAVIOUR
//  Reset: FIFO_EMPTY=1, FIFO_DATA=0, FE_FIFO_READ=0, TLU_DATA_SAVED_FLAG=0,
//   TLU_OVERFLOW=0, READ_ERROR=0, TLU buffer emptied; in-flight words discarded.
//  TLU capture: SAVE_FLAG & !full -> push {1'b1,TLU_DATA}, SAVED_FLAG next cycle.
//   SAVE_FLAG & full -> word dropped, no SAVED_FLAG, TLU_OVERFLOW set until reset.
//   Push and pop in same cycle on full buffer: pop frees slot, push accepted.
//  Output register states: EMPTY (FIFO_EMPTY=1) / HOLD (FIFO_EMPTY=0).
//   LOAD condition = EMPTY, or HOLD & FIFO_READ_NEXT.
//   On LOAD: TLU buffer non-empty -> pop TLU word into output register;
//    else !FE_FIFO_EMPTY -> capture {8'h00,FE_FIFO_DATA}, FE_FIFO_READ=1 same cycle;
//    else -> EMPTY.
//  Latency: source word present at edge N -> FIFO_EMPTY=0 after edge N+1.
//  Back-to-back: READ_NEXT every cycle sustains 1 word/cycle, no bubbles.
//  FE_FIFO_READ never asserted while FE_FIFO_EMPTY=1 or output register held.
//  READ_NEXT while EMPTY: ignored, READ_ERROR set until reset.
//  TLU word never overtaken: TLU word buffered at edge N is output before any FE
//   word loaded after edge N.
// CONFIGURATION
//  `define RX_TLU_ARB_HEADER_EN: FE words output as {FE_HEADER,FE_FIFO_DATA};
//   FE_HEADER[7] forced to 0 to keep bit31 as source flag.
//  Not defined: FE words output as {8'h00,FE_FIFO_DATA}; FE_HEADER unused.
// STRUCTURE
//  arb_pkg: word-type bit index (31), FE/TLU widths, default header constant.
//  Sub-module arb_tlu_buf: TLU_DEPTH x 32 sync FWFT buffer, full/empty by
//   wrap-bit pointer compare. Arbiter FSM + output register in top module.
// TESTING
//  5 FE words, READ_NEXT held high -> 5 outputs {8'h00,data} in order, no gaps.
//  TLU pulse 31'h0000_1234 while FE stream active -> 32'h8000_1234 at next LOAD,
//   SAVED_FLAG pulse 1 cycle after SAVE_FLAG.
//  5 TLU pulses, READ_NEXT low, TLU_DEPTH=4 -> 4 SAVED_FLAGs, TLU_OVERFLOW=1,
//   drain gives first 4 words only.
//  READ_NEXT while FIFO_EMPTY=1 -> READ_ERROR=1, FIFO_DATA/FE_FIFO_READ unchanged.
//  BUS_RST mid-burst with 2 words buffered -> outputs at reset values, no pops.
//  With RX_TLU_ARB_HEADER_EN, FE 24'hABCDEF -> 32'h01AB_CDEF.

Source files
------------

// File: rtl/rx_tlu_arbiter_pkg.sv
// Shared widths, word-type flag position, default FE header and output-register states
// for the FE/TLU receive arbiter.
package rx_tlu_arbiter_pkg;

  localparam int WORD_TYPE_BIT = 31;
  localparam int FE_W          = 24;
  localparam int TLU_W         = 31;
  localparam int OUT_W         = 32;

  localparam logic [7:0] FE_HEADER_DEFAULT = 8'h01;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_HOLD  = 1'b1
  } out_state_t;

  function automatic logic [OUT_W-1:0] tlu_word(input logic [TLU_W-1:0] d);
    logic [OUT_W-1:0] w;
    w = {1'b0, d};
    w[WORD_TYPE_BIT] = 1'b1;
    return w;
  endfunction

  // The source flag always wins over whatever the header byte carries in bit 31.
  function automatic logic [OUT_W-1:0] fe_word(input logic [7:0] hdr, input logic [FE_W-1:0] d);
    logic [OUT_W-1:0] w;
    w = {hdr, d};
    w[WORD_TYPE_BIT] = 1'b0;
    return w;
  endfunction

endpackage

// File: rtl/rx_tlu_arbiter_tlu_buf.sv
// Synchronous first-word-fall-through buffer for TLU words; full/empty come from
// wrap-bit pointer comparison, so the caller must only push when there is room.
module rx_tlu_arbiter_tlu_buf #(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic [W-1:0] mem [DEPTH];

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign dout  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/rx_tlu_arbiter.sv
// Merges FE-I4 words and priority TLU words into one 32-bit FWFT stream (bit31 = TLU).
// Define RX_TLU_ARB_HEADER_EN to place FE_HEADER in bits [30:24] of FE words.
module rx_tlu_arbiter
  import rx_tlu_arbiter_pkg::*;
#(
  parameter int         TLU_DEPTH = 4,
  parameter logic [7:0] FE_HEADER = FE_HEADER_DEFAULT
) (
  input  logic              BUS_CLK,
  input  logic              BUS_RST,
  input  logic              FE_FIFO_EMPTY,
  input  logic [FE_W-1:0]   FE_FIFO_DATA,
  output logic              FE_FIFO_READ,
  input  logic              TLU_DATA_SAVE_FLAG,
  input  logic [TLU_W-1:0]  TLU_DATA,
  output logic              TLU_DATA_SAVED_FLAG,
  input  logic              FIFO_READ_NEXT,
  output logic              FIFO_EMPTY,
  output logic [OUT_W-1:0]  FIFO_DATA,
  output logic              TLU_OVERFLOW,
  output logic              READ_ERROR
);

`ifdef RX_TLU_ARB_HEADER_EN
  localparam logic [7:0] FE_HDR_EFF = FE_HEADER;
`else
  // Header parameter stays in the interface but is masked off in this build.
  localparam logic [7:0] FE_HDR_EFF = FE_HEADER & 8'h00;
`endif

  out_state_t       state;
  logic             load;
  logic             tlu_push;
  logic             tlu_pop;
  logic             tlu_full;
  logic             tlu_empty;
  logic             fe_take;
  logic [OUT_W-1:0] tlu_head;

  assign load     = (state == ST_EMPTY) || FIFO_READ_NEXT;
  assign tlu_pop  = load && !tlu_empty;
  assign fe_take  = load && tlu_empty && !FE_FIFO_EMPTY && !BUS_RST;
  // A pop in the same cycle frees the slot the push needs.
  assign tlu_push = TLU_DATA_SAVE_FLAG && (!tlu_full || tlu_pop);

  assign FE_FIFO_READ = fe_take;
  assign FIFO_EMPTY   = (state == ST_EMPTY);

  rx_tlu_arbiter_tlu_buf #(
    .DEPTH (TLU_DEPTH),
    .W     (OUT_W)
  ) u_tlu_buf (
    .clk   (BUS_CLK),
    .rst   (BUS_RST),
    .push  (tlu_push),
    .din   (tlu_word(TLU_DATA)),
    .pop   (tlu_pop),
    .dout  (tlu_head),
    .full  (tlu_full),
    .empty (tlu_empty)
  );

  always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
    if (BUS_RST) begin
      state               <= ST_EMPTY;
      FIFO_DATA           <= '0;
      TLU_DATA_SAVED_FLAG <= 1'b0;
      TLU_OVERFLOW        <= 1'b0;
      READ_ERROR          <= 1'b0;
    end else begin
      TLU_DATA_SAVED_FLAG <= tlu_push;
      if (TLU_DATA_SAVE_FLAG && !tlu_push) TLU_OVERFLOW <= 1'b1;
      if (FIFO_READ_NEXT && (state == ST_EMPTY)) READ_ERROR <= 1'b1;
      if (load) begin
        if (tlu_pop) begin
          state     <= ST_HOLD;
          FIFO_DATA <= tlu_head;
        end else if (fe_take) begin
          state     <= ST_HOLD;
          FIFO_DATA <= fe_word(FE_HDR_EFF, FE_FIFO_DATA);
        end else begin
          state     <= ST_EMPTY;
        end
      end
    end
  end

endmodule

// File: tb/tb_rx_tlu_arbiter.sv
// Directed bench for rx_tlu_arbiter: FE source model, scoreboard of expected output words.
module tb_rx_tlu_arbiter;

  logic        BUS_CLK = 1'b0;
  logic        BUS_RST = 1'b1;
  logic        FE_FIFO_EMPTY;
  logic [23:0] FE_FIFO_DATA;
  logic        FE_FIFO_READ;
  logic        TLU_DATA_SAVE_FLAG = 1'b0;
  logic [30:0] TLU_DATA = '0;
  logic        TLU_DATA_SAVED_FLAG;
  logic        FIFO_READ_NEXT = 1'b0;
  logic        FIFO_EMPTY;
  logic [31:0] FIFO_DATA;
  logic        TLU_OVERFLOW;
  logic        READ_ERROR;

  always #5 BUS_CLK = ~BUS_CLK;

  rx_tlu_arbiter #(.TLU_DEPTH(4), .FE_HEADER(8'h01)) dut (
    .BUS_CLK             (BUS_CLK),
    .BUS_RST             (BUS_RST),
    .FE_FIFO_EMPTY       (FE_FIFO_EMPTY),
    .FE_FIFO_DATA        (FE_FIFO_DATA),
    .FE_FIFO_READ        (FE_FIFO_READ),
    .TLU_DATA_SAVE_FLAG  (TLU_DATA_SAVE_FLAG),
    .TLU_DATA            (TLU_DATA),
    .TLU_DATA_SAVED_FLAG (TLU_DATA_SAVED_FLAG),
    .FIFO_READ_NEXT      (FIFO_READ_NEXT),
    .FIFO_EMPTY          (FIFO_EMPTY),
    .FIFO_DATA           (FIFO_DATA),
    .TLU_OVERFLOW        (TLU_OVERFLOW),
    .READ_ERROR          (READ_ERROR)
  );

  // FE-side FWFT source model
  logic [23:0] fe_mem [64];
  int          fe_wr = 0;
  int          fe_rd = 0;
  assign FE_FIFO_EMPTY = (fe_wr == fe_rd);
  assign FE_FIFO_DATA  = fe_mem[fe_rd[5:0]];
  always @(posedge BUS_CLK) if (FE_FIFO_READ) fe_rd <= fe_rd + 1;

  logic [31:0] exp_q[$];
  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] fe_exp(input logic [23:0] d);
`ifdef RX_TLU_ARB_HEADER_EN
    return {8'h01, d};
`else
    return {8'h00, d};
`endif
  endfunction

  task automatic tick();
    @(posedge BUS_CLK);
    #1;
  endtask

  task automatic fe_push(input logic [23:0] d, input bit expect_out);
    fe_mem[fe_wr[5:0]] = d;
    fe_wr++;
    if (expect_out) exp_q.push_back(fe_exp(d));
  endtask

  task automatic drain(input string tag);
    FIFO_READ_NEXT = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (exp_q.size() == 0) break;
    end
    FIFO_READ_NEXT = 1'b0;
    chk(tag, exp_q.size(), 0);
  endtask

  // Output monitor: words are transferred on edges where READ_NEXT is high.
  always @(negedge BUS_CLK) begin
    if (!BUS_RST) begin
      chk("fe_read_illegal", {31'b0, FE_FIFO_READ && (FE_FIFO_EMPTY || (!FIFO_EMPTY && !FIFO_READ_NEXT))}, 32'd0);
      if (FIFO_READ_NEXT && exp_q.size() > 0) begin
        chk("bubble", {31'b0, FIFO_EMPTY}, 32'd0);
        if (!FIFO_EMPTY) chk("data", FIFO_DATA, exp_q.pop_front());
      end else if (FIFO_READ_NEXT) begin
        chk("extra_word", {31'b0, !FIFO_EMPTY}, 32'd0);
      end
    end
  end

  int n_saved;
  int rd_snap;

  initial begin
    // reset state
    repeat (3) tick();
    chk("rst_empty", FIFO_EMPTY, 1);
    chk("rst_data", FIFO_DATA, 0);
    chk("rst_fe_read", FE_FIFO_READ, 0);
    chk("rst_saved", TLU_DATA_SAVED_FLAG, 0);
    chk("rst_ovf", TLU_OVERFLOW, 0);
    chk("rst_rderr", READ_ERROR, 0);
    BUS_RST = 1'b0;
    tick();

    // FE burst, back-to-back reads
    for (int i = 0; i < 5; i++) fe_push(24'h100000 + 24'(i) * 24'h010101, 1'b1);
    tick();
    chk("fe_latency", FIFO_EMPTY, 0);
    drain("fe_burst");
    chk("fe_burst_empty", FIFO_EMPTY, 1);
    chk("fe_burst_rderr", READ_ERROR, 0);

    // TLU word merged into an active FE stream
    fe_push(24'h200001, 1'b1);
    fe_push(24'h200002, 1'b1);
    exp_q.push_back(32'h8000_1234);
    fe_push(24'h200003, 1'b1);
    fe_push(24'h200004, 1'b1);
    tick();
    FIFO_READ_NEXT     = 1'b1;
    TLU_DATA           = 31'h0000_1234;
    TLU_DATA_SAVE_FLAG = 1'b1;
    chk("saved_before", TLU_DATA_SAVED_FLAG, 0);
    tick();
    TLU_DATA_SAVE_FLAG = 1'b0;
    chk("saved_pulse", TLU_DATA_SAVED_FLAG, 1);
    tick();
    chk("saved_after", TLU_DATA_SAVED_FLAG, 0);
    drain("tlu_mix");
    chk("tlu_mix_rderr", READ_ERROR, 0);

    // TLU overflow with the output register held
    fe_push(24'h300000, 1'b1);
    tick();
    n_saved = 0;
    for (int i = 0; i < 5; i++) begin
      TLU_DATA           = 31'h0000_0A00 + 31'(i);
      TLU_DATA_SAVE_FLAG = 1'b1;
      if (i < 4) exp_q.push_back({1'b1, 31'h0000_0A00 + 31'(i)});
      tick();
      n_saved += int'(TLU_DATA_SAVED_FLAG);
      if (i < 4) chk("ovf_early", TLU_OVERFLOW, 0);
    end
    TLU_DATA_SAVE_FLAG = 1'b0;
    tick();
    n_saved += int'(TLU_DATA_SAVED_FLAG);
    chk("ovf_saved_cnt", n_saved, 4);
    chk("ovf_flag", TLU_OVERFLOW, 1);
    drain("tlu_ovf");

    // read while empty
    FIFO_READ_NEXT = 1'b1;
    tick();
    FIFO_READ_NEXT = 1'b0;
    chk("rderr_flag", READ_ERROR, 1);
    chk("rderr_data", FIFO_DATA, 32'h8000_0A03);
    chk("rderr_empty", FIFO_EMPTY, 1);
    chk("rderr_fe_read", FE_FIFO_READ, 0);

    // reset with a held word, two buffered TLU words and pending FE words
    fe_push(24'h00A0A0, 1'b0);
    tick();
    for (int i = 0; i < 2; i++) begin
      TLU_DATA           = 31'h0000_0B00 + 31'(i);
      TLU_DATA_SAVE_FLAG = 1'b1;
      tick();
    end
    TLU_DATA_SAVE_FLAG = 1'b0;
    fe_push(24'h00B0B0, 1'b0);
    fe_push(24'h00C0C0, 1'b0);
    rd_snap = fe_rd;
    BUS_RST = 1'b1;
    #1;
    chk("mid_rst_empty", FIFO_EMPTY, 1);
    chk("mid_rst_data", FIFO_DATA, 0);
    chk("mid_rst_fe_read", FE_FIFO_READ, 0);
    chk("mid_rst_saved", TLU_DATA_SAVED_FLAG, 0);
    chk("mid_rst_ovf", TLU_OVERFLOW, 0);
    chk("mid_rst_rderr", READ_ERROR, 0);
    tick();
    tick();
    chk("mid_rst_no_pop", fe_rd, rd_snap);
    BUS_RST = 1'b0;
    exp_q.push_back(fe_exp(24'h00B0B0));
    exp_q.push_back(fe_exp(24'h00C0C0));
    tick();
    chk("post_rst_tlu_flushed", FIFO_DATA, fe_exp(24'h00B0B0));
    drain("post_rst");

    // header placement
    fe_push(24'hABCDEF, 1'b1);
    tick();
    chk("hdr_word", FIFO_DATA, fe_exp(24'hABCDEF));
    drain("hdr");
    tick();
    chk("final_empty", FIFO_EMPTY, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
